// File: rtl/guess_pkg.sv
// Shared constants, state encoding and helpers for the guess checker and the guess-entry stage.
package guess_pkg;

    localparam int NUM_PEGS  = 4;
    localparam int COLOR_W   = 3;
    localparam int MAX_TRIES = 10;
    localparam int CNT_W     = 3;
    localparam int ATT_W     = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXACT   = 3'd1,
        S_PARTIAL = 3'd2,
        S_REPORT  = 3'd3,
        S_OVER    = 3'd4
    } state_t;

    function automatic logic [CNT_W-1:0] count_ones(input logic [NUM_PEGS-1:0] bits);
        logic [CNT_W-1:0] total;
        total = '0;
        for (int i = 0; i < NUM_PEGS; i++) begin
            total = total + CNT_W'(bits[i]);
        end
        return total;
    endfunction

endpackage

// File: rtl/guess_checker_first_free_match.sv
// Combinational search: finds the lowest-index unmatched secret peg whose colour equals the given one.
module first_free_match
    import guess_pkg::*;
(
    input  logic [COLOR_W-1:0]               color,
    input  logic [NUM_PEGS-1:0][COLOR_W-1:0] secrets,
    input  logic [NUM_PEGS-1:0]              matched,
    output logic                             hit,
    output logic [NUM_PEGS-1:0]              onehot
);

    logic [NUM_PEGS-1:0] eligible;
    logic [NUM_PEGS-1:0] eligible_neg;

    generate
        for (genvar gi = 0; gi < NUM_PEGS; gi++) begin : g_elig
            assign eligible[gi] = !matched[gi] && (secrets[gi] == color);
        end
    endgenerate

    // Two's-complement trick isolates the lowest set bit.
    assign eligible_neg = ~eligible + NUM_PEGS'(1);
    assign onehot       = eligible & eligible_neg;
    assign hit          = |eligible;

endmodule

// File: rtl/guess_checker.sv
// Scores one guess against the loaded secret over several cycles (exact pass, then one partial
// peg per cycle) and tracks attempts and win/lose for the current game.
module guess_checker
    import guess_pkg::*;
#(
    parameter int NUM_PEGS_P  = NUM_PEGS,
    parameter int COLOR_W_P   = COLOR_W,
    parameter int MAX_TRIES_P = MAX_TRIES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_secret,
    input  logic [COLOR_W-1:0]   secret_zero,
    input  logic [COLOR_W-1:0]   secret_one,
    input  logic [COLOR_W-1:0]   secret_two,
    input  logic [COLOR_W-1:0]   secret_three,
    input  logic                 submit,
    input  logic [COLOR_W-1:0]   guess_zero,
    input  logic [COLOR_W-1:0]   guess_one,
    input  logic [COLOR_W-1:0]   guess_two,
    input  logic [COLOR_W-1:0]   guess_three,
    output logic [CNT_W-1:0]     exact,
    output logic [CNT_W-1:0]     partial,
    output logic                 result_valid,
    output logic                 busy,
    output logic [ATT_W-1:0]     attempts,
    output logic                 win,
    output logic                 lose
);

    localparam logic [ATT_W-1:0] MAX_T    = ATT_W'(MAX_TRIES_P);
    localparam logic [CNT_W-1:0] ALL_PEGS = CNT_W'(NUM_PEGS_P);
    localparam logic [1:0]       LAST_K   = 2'(NUM_PEGS - 1);

    state_t state_q, state_d;

    logic [NUM_PEGS-1:0][COLOR_W-1:0] secret_q, secret_d;
    logic [NUM_PEGS-1:0][COLOR_W-1:0] guess_q, guess_d;
    logic [NUM_PEGS-1:0]              gmatch_q, gmatch_d;
    logic [NUM_PEGS-1:0]              smatch_q, smatch_d;
    logic [1:0]                       k_q, k_d;
    logic [CNT_W-1:0]                 exact_acc_q, exact_acc_d;
    logic [CNT_W-1:0]                 partial_acc_q, partial_acc_d;
    logic [CNT_W-1:0]                 exact_q, exact_d;
    logic [CNT_W-1:0]                 partial_q, partial_d;
    logic                             result_valid_q, result_valid_d;
    logic [ATT_W-1:0]                 attempts_q, attempts_d;
    logic                             win_q, win_d;
    logic                             lose_q, lose_d;

    logic [NUM_PEGS-1:0] pos_eq;
    logic                ffm_hit;
    logic [NUM_PEGS-1:0] ffm_onehot;

    generate
        for (genvar gi = 0; gi < NUM_PEGS; gi++) begin : g_pos
            assign pos_eq[gi] = (guess_q[gi] == secret_q[gi]);
        end
    endgenerate

    first_free_match u_ffm (
        .color   (guess_q[k_q]),
        .secrets (secret_q),
        .matched (smatch_q),
        .hit     (ffm_hit),
        .onehot  (ffm_onehot)
    );

    always_comb begin
        state_d        = state_q;
        secret_d       = secret_q;
        guess_d        = guess_q;
        gmatch_d       = gmatch_q;
        smatch_d       = smatch_q;
        k_d            = k_q;
        exact_acc_d    = exact_acc_q;
        partial_acc_d  = partial_acc_q;
        exact_d        = exact_q;
        partial_d      = partial_q;
        result_valid_d = 1'b0;
        attempts_d     = attempts_q;
        win_d          = win_q;
        lose_d         = lose_q;

        case (state_q)
            S_IDLE: begin
                if (submit) begin
                    guess_d       = {guess_three, guess_two, guess_one, guess_zero};
                    gmatch_d      = '0;
                    smatch_d      = '0;
                    exact_acc_d   = '0;
                    partial_acc_d = '0;
                    state_d       = S_EXACT;
                end
            end
            S_EXACT: begin
                gmatch_d    = pos_eq;
                smatch_d    = pos_eq;
                exact_acc_d = count_ones(pos_eq);
                k_d         = 2'd0;
                state_d     = S_PARTIAL;
            end
            S_PARTIAL: begin
                // Exact-matched guess pegs are already accounted for and must not claim a secret.
                if (!gmatch_q[k_q] && ffm_hit) begin
                    smatch_d      = smatch_q | ffm_onehot;
                    partial_acc_d = partial_acc_q + CNT_W'(1);
                end
                if (k_q == LAST_K) begin
                    state_d = S_REPORT;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            S_REPORT: begin
                exact_d        = exact_acc_q;
                partial_d      = partial_acc_q;
                result_valid_d = 1'b1;
                if (attempts_q < MAX_T) begin
                    attempts_d = attempts_q + ATT_W'(1);
                end
                if (exact_acc_q == ALL_PEGS) begin
                    win_d   = 1'b1;
                    state_d = S_OVER;
                end else if (attempts_d == MAX_T) begin
                    lose_d  = 1'b1;
                    state_d = S_OVER;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OVER: begin
                state_d = S_OVER;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new game takes priority over everything, including a pending submit or evaluation.
        if (load_secret) begin
            secret_d       = {secret_three, secret_two, secret_one, secret_zero};
            gmatch_d       = '0;
            smatch_d       = '0;
            k_d            = 2'd0;
            exact_acc_d    = '0;
            partial_acc_d  = '0;
            exact_d        = '0;
            partial_d      = '0;
            result_valid_d = 1'b0;
            attempts_d     = '0;
            win_d          = 1'b0;
            lose_d         = 1'b0;
            state_d        = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            secret_q       <= '0;
            guess_q        <= '0;
            gmatch_q       <= '0;
            smatch_q       <= '0;
            k_q            <= 2'd0;
            exact_acc_q    <= '0;
            partial_acc_q  <= '0;
            exact_q        <= '0;
            partial_q      <= '0;
            result_valid_q <= 1'b0;
            attempts_q     <= '0;
            win_q          <= 1'b0;
            lose_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            secret_q       <= secret_d;
            guess_q        <= guess_d;
            gmatch_q       <= gmatch_d;
            smatch_q       <= smatch_d;
            k_q            <= k_d;
            exact_acc_q    <= exact_acc_d;
            partial_acc_q  <= partial_acc_d;
            exact_q        <= exact_d;
            partial_q      <= partial_d;
            result_valid_q <= result_valid_d;
            attempts_q     <= attempts_d;
            win_q          <= win_d;
            lose_q         <= lose_d;
        end
    end

    assign exact        = exact_q;
    assign partial      = partial_q;
    assign result_valid = result_valid_q;
    assign busy         = (state_q == S_EXACT) || (state_q == S_PARTIAL) || (state_q == S_REPORT);
    assign attempts     = attempts_q;
    assign win          = win_q;
    assign lose         = lose_q;

endmodule

// File: tb/tb_guess_checker.sv
// Directed bench for guess_checker: table of scoring vectors plus hand-written game sequences.
module tb_guess_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_secret;
    logic [2:0] secret_zero, secret_one, secret_two, secret_three;
    logic       submit;
    logic [2:0] guess_zero, guess_one, guess_two, guess_three;
    logic [2:0] exact, partial;
    logic       result_valid, busy;
    logic [3:0] attempts;
    logic       win, lose;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int s0, s1, s2, s3;
        int g0, g1, g2, g3;
        int e, p;
    } vec_t;

    vec_t vecs[7];

    guess_checker dut (
        .clk          (clk),
        .rst          (rst),
        .load_secret  (load_secret),
        .secret_zero  (secret_zero),
        .secret_one   (secret_one),
        .secret_two   (secret_two),
        .secret_three (secret_three),
        .submit       (submit),
        .guess_zero   (guess_zero),
        .guess_one    (guess_one),
        .guess_two    (guess_two),
        .guess_three  (guess_three),
        .exact        (exact),
        .partial      (partial),
        .result_valid (result_valid),
        .busy         (busy),
        .attempts     (attempts),
        .win          (win),
        .lose         (lose)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic do_load(input int s0, input int s1, input int s2, input int s3);
        secret_zero  = 3'(s0);
        secret_one   = 3'(s1);
        secret_two   = 3'(s2);
        secret_three = 3'(s3);
        load_secret  = 1'b1;
        @(posedge clk);
        #1;
        load_secret  = 1'b0;
    endtask

    // Pulses submit at edge N and returns the cycle offset at which result_valid is seen (-1 if none).
    task automatic do_submit(input int g0, input int g1, input int g2, input int g3,
                             input int budget, output int lat);
        guess_zero  = 3'(g0);
        guess_one   = 3'(g1);
        guess_two   = 3'(g2);
        guess_three = 3'(g3);
        submit      = 1'b1;
        @(posedge clk);
        #1;
        submit = 1'b0;
        lat = -1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk);
            #1;
            if (result_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int rv_seen;

        vecs[0] = '{s0:1, s1:2, s2:3, s3:4, g0:1, g1:2, g2:3, g3:4, e:4, p:0};
        vecs[1] = '{s0:1, s1:1, s2:2, s3:2, g0:2, g1:2, g2:1, g3:1, e:0, p:4};
        vecs[2] = '{s0:1, s1:2, s2:3, s3:4, g0:1, g1:1, g2:1, g3:1, e:1, p:0};
        vecs[3] = '{s0:5, s1:5, s2:0, s3:7, g0:0, g1:5, g2:5, g3:5, e:1, p:2};
        vecs[4] = '{s0:1, s1:2, s2:3, s3:4, g0:4, g1:3, g2:2, g3:1, e:0, p:4};
        vecs[5] = '{s0:6, s1:6, s2:1, s3:2, g0:6, g1:1, g2:6, g3:6, e:1, p:2};
        vecs[6] = '{s0:3, s1:4, s2:5, s3:6, g0:0, g1:1, g2:2, g3:7, e:0, p:0};

        rst = 1'b1;
        load_secret = 1'b0;
        submit = 1'b0;
        secret_zero = 3'd0; secret_one = 3'd0; secret_two = 3'd0; secret_three = 3'd0;
        guess_zero = 3'd0; guess_one = 3'd0; guess_two = 3'd0; guess_three = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_exact", exact, 0);
        check("rst_partial", partial, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_attempts", attempts, 0);
        check("rst_win", win, 0);
        check("rst_lose", lose, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // No load_secret yet: secret defaults to all zeros.
        do_submit(0, 0, 0, 0, 12, lat);
        check("nosecret_latency", lat, 6);
        check("nosecret_exact", exact, 4);
        check("nosecret_win", win, 1);
        $display("nosecret: lat=%0d exact=%0d partial=%0d win=%0d", lat, exact, partial, win);

        foreach (vecs[i]) begin
            do_load(vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3);
            check($sformatf("v%0d_cleared_attempts", i), attempts, 0);
            check($sformatf("v%0d_cleared_win", i), win, 0);
            do_submit(vecs[i].g0, vecs[i].g1, vecs[i].g2, vecs[i].g3, 12, lat);
            check($sformatf("v%0d_latency", i), lat, 6);
            check($sformatf("v%0d_exact", i), exact, vecs[i].e);
            check($sformatf("v%0d_partial", i), partial, vecs[i].p);
            check($sformatf("v%0d_attempts", i), attempts, 1);
            check($sformatf("v%0d_busy", i), busy, 0);
            check($sformatf("v%0d_win", i), win, (vecs[i].e == 4) ? 1 : 0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_rv_low", i), result_valid, 0);
            check($sformatf("v%0d_exact_hold", i), exact, vecs[i].e);
            check($sformatf("v%0d_partial_hold", i), partial, vecs[i].p);
            $display("vec%0d: lat=%0d exact=%0d partial=%0d attempts=%0d win=%0d",
                     i, lat, exact, partial, attempts, win);
        end

        // Won game: later submits are ignored.
        do_load(1, 2, 3, 4);
        do_submit(1, 2, 3, 4, 12, lat);
        check("win_latency", lat, 6);
        check("win_flag", win, 1);
        do_submit(5, 5, 5, 5, 10, lat);
        check("win_submit_ignored", lat, -1);
        check("win_attempts_hold", attempts, 1);
        check("win_busy", busy, 0);
        $display("win_game: ignored_submit_lat=%0d attempts=%0d", lat, attempts);

        // Losing game: ten misses, then an eleventh submit is ignored.
        do_load(7, 7, 7, 7);
        for (int t = 1; t <= 10; t++) begin
            do_submit(0, 0, 0, 0, 12, lat);
            check($sformatf("lose_t%0d_latency", t), lat, 6);
            check($sformatf("lose_t%0d_attempts", t), attempts, t);
            check($sformatf("lose_t%0d_lose", t), lose, (t == 10) ? 1 : 0);
            $display("lose_try%0d: lat=%0d attempts=%0d lose=%0d", t, lat, attempts, lose);
        end
        check("lose_win_clear", win, 0);
        do_submit(0, 0, 0, 0, 10, lat);
        check("lose_11th_ignored", lat, -1);
        check("lose_attempts_cap", attempts, 10);
        check("lose_sticky", lose, 1);

        // Abort mid-evaluation with load_secret while in PARTIAL.
        do_load(1, 2, 3, 4);
        guess_zero = 3'd1; guess_one = 3'd2; guess_two = 3'd3; guess_three = 3'd4;
        submit = 1'b1;
        @(posedge clk);
        #1;
        submit = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort_busy_before", busy, 1);
        rv_seen = 0;
        secret_zero = 3'd2; secret_one = 3'd2; secret_two = 3'd2; secret_three = 3'd2;
        load_secret = 1'b1;
        @(posedge clk);
        #1;
        load_secret = 1'b0;
        check("abort_busy_after", busy, 0);
        check("abort_attempts", attempts, 0);
        for (int c = 0; c < 10; c++) begin
            if (result_valid) rv_seen++;
            @(posedge clk);
            #1;
        end
        check("abort_no_result", rv_seen, 0);
        check("abort_lose_clear", lose, 0);
        $display("abort: busy=%0d attempts=%0d results=%0d", busy, attempts, rv_seen);

        // load_secret and submit together: submit is dropped.
        secret_zero = 3'd3; secret_one = 3'd3; secret_two = 3'd3; secret_three = 3'd3;
        guess_zero = 3'd3; guess_one = 3'd3; guess_two = 3'd3; guess_three = 3'd3;
        load_secret = 1'b1;
        submit = 1'b1;
        @(posedge clk);
        #1;
        load_secret = 1'b0;
        submit = 1'b0;
        check("same_cycle_busy", busy, 0);
        rv_seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (result_valid) rv_seen++;
            @(posedge clk);
            #1;
        end
        check("same_cycle_no_result", rv_seen, 0);
        check("same_cycle_attempts", attempts, 0);
        // The new secret is live: a follow-up submit scores it.
        do_submit(3, 3, 3, 3, 12, lat);
        check("same_cycle_followup_exact", exact, 4);
        $display("same_cycle: results=%0d followup_exact=%0d", rv_seen, exact);

        // Asynchronous reset mid-game clears everything.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_attempts", attempts, 0);
        check("async_rst_win", win, 0);
        check("async_rst_exact", exact, 0);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/guess_checker.md
GUESS_CHECKER -- requirements
Module: guess_checker

Interface
REQ-001 Parameter: NUM_PEGS, 4, number of peg positions; fixed at 4.
REQ-002 Parameter: COLOR_W, 3, bits per peg colour.
REQ-003 Parameter: MAX_TRIES, 10, guesses allowed per game; range 1..15.
REQ-004 Port: clk  in  1  single system clock; all state changes on its rising edge.
REQ-005 Port: rst  in  1  asynchronous, active-high reset.
REQ-006 Port: load_secret  in  1  one-cycle pulse; latch secret_* and start a new game.
REQ-007 Port: secret_zero, secret_one, secret_two, secret_three  in  3 each  code colours, sampled only on load_secret.
REQ-008 Port: submit  in  1  one-cycle pulse; evaluate the current guess.
REQ-009 Port: guess_zero, guess_one, guess_two, guess_three  in  3 each  guess colours from the entry stage, sampled only on an accepted submit.
REQ-010 Port: exact  out  3  count of right colour in right position, 0..4.
REQ-011 Port: partial  out  3  count of right colour in wrong position, 0..4.
REQ-012 Port: result_valid  out  1  one-cycle pulse; exact/partial are new.
REQ-013 Port: busy  out  1  high while an evaluation is in progress.
REQ-014 Port: attempts  out  4  guesses scored in the current game.
REQ-015 Port: win / lose  out  1 each  game-over flags; sticky until load_secret or rst.

Function
REQ-016 States SHALL be IDLE, EXACT, PARTIAL, REPORT and OVER.
REQ-017 In IDLE, submit high at edge N SHALL latch all guess_* values and go to EXACT; busy SHALL be high from edge N until the edge that leaves REPORT.
REQ-018 EXACT (one cycle) SHALL compare all four positions in parallel, count matches into an exact accumulator and set a matched flag on each matched guess/secret pair.
REQ-019 PARTIAL SHALL last exactly 4 cycles, index k = 0..3, one guess position per cycle.
REQ-020 In each PARTIAL cycle, an unmatched guess k SHALL claim the lowest-index unmatched secret of equal colour, set that secret's flag and add 1 to partial.
REQ-021 Each secret peg SHALL be counted at most once, so duplicate colours never over-count.
REQ-022 In REPORT, exact and partial SHALL be registered, result_valid SHALL be high for that one cycle only, and attempts SHALL increment.
REQ-023 Latency: result_valid SHALL be sampled high at edge N+6 and low at edge N+7.
REQ-024 From REPORT, exact == 4 SHALL set win and go to OVER; otherwise, if attempts reaches MAX_TRIES, lose SHALL be set and the block SHALL go to OVER; otherwise it SHALL return to IDLE.
REQ-025 exact and partial SHALL hold their values until the next REPORT, load_secret or rst.
REQ-026 submit SHALL be ignored when not in IDLE, i.e. while busy or in OVER.
REQ-027 load_secret in any state SHALL, at that edge: latch secret_*, clear attempts/exact/partial/win/lose/matched flags and go to IDLE.
REQ-028 load_secret during an evaluation SHALL abort it with no result_valid.
REQ-029 load_secret and submit in the same cycle: load_secret SHALL win and submit SHALL be dropped.
REQ-030 All 8 colour values SHALL be legal, and no colour value SHALL be special.
REQ-031 attempts SHALL never exceed MAX_TRIES and SHALL not wrap.
REQ-032 win and lose SHALL be mutually exclusive.

Reset
REQ-033 rst high SHALL asynchronously force: state IDLE; exact 0, partial 0, result_valid 0, busy 0, attempts 0, win 0, lose 0; secret and guess registers 0; matched flags clear.
REQ-034 rst SHALL override load_secret and submit.
REQ-035 After reset, a submit without a prior load_secret SHALL score against secret 0,0,0,0.

Structure
REQ-036 Shared package guess_pkg SHALL hold NUM_PEGS, COLOR_W, MAX_TRIES and the state encoding.
REQ-037 The upstream guess-entry stage SHALL use guess_pkg for its colour width.
REQ-038 Sub-module first_free_match (combinational) SHALL, given one colour, four secret colours and four matched flags, return hit and a one-hot index of the lowest-index eligible secret.

Verification
REQ-039 Secret 1,2,3,4; guess 1,2,3,4 -> result_valid at N+6, exact 4, partial 0, attempts 1, win 1; a further submit is ignored.
REQ-040 Secret 1,1,2,2; guess 2,2,1,1 -> exact 0, partial 4.
REQ-041 Secret 1,2,3,4; guess 1,1,1,1 -> exact 1, partial 0 (duplicate guard).
REQ-042 Secret 5,5,0,7; guess 0,5,5,5 -> exact 1, partial 2.
REQ-043 Secret 7,7,7,7; ten guesses 0,0,0,0 -> lose 1 after the 10th result_valid, attempts 10; an 11th submit produces no result_valid.
REQ-044 load_secret during the PARTIAL state -> no result_valid, busy low the next cycle, attempts 0; load_secret and submit in the same cycle -> submit dropped.
